// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter and sequencer for a shared 16:1 single-bit mux channel.
// Bounded grant bursts with a one-cycle turnaround; the selected bit is captured with a valid strobe.
module mux16_rr_arbiter #(
    parameter int MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [0:15] req,
    input  logic        mux_out,
    output logic [0:3]  sel,
    output logic [0:15] grant,
    output logic        busy,
    output logic        data_out,
    output logic        data_valid
);

    localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  ptr_q, ptr_d;
    logic [0:3]  sel_q, sel_d;
    logic [0:15] grant_q, grant_d;
    logic        busy_q, busy_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        data_q, data_d;
    logic        valid_q, valid_d;

    logic [3:0]  win;
    logic [3:0]  cand;
    logic        found;
    logic        any_req;
    logic        req_sel;

    assign any_req = |req;
    assign req_sel = req[sel_q];

    // First requesting index at or after the pointer, wrapping modulo 16.
    always_comb begin
        win   = ptr_q;
        cand  = ptr_q;
        found = 1'b0;
        for (int i = 0; i < 16; i++) begin
            cand = ptr_q + 4'(i);
            if (!found && req[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        grant_d = grant_q;
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        data_d  = mux_out;
        valid_d = (state_q == GRANT) && req_sel;
        case (state_q)
            IDLE, GAP: begin
                if (any_req) begin
                    state_d      = GRANT;
                    sel_d        = win;
                    grant_d      = '0;
                    grant_d[win] = 1'b1;
                    busy_d       = 1'b1;
                    cnt_d        = 4'd1;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                // sel is kept through the gap; only the pointer moves on.
                if (!req_sel || (cnt_q == BURST_MAX)) begin
                    state_d = GAP;
                    grant_d = '0;
                    busy_d  = 1'b0;
                    ptr_d   = sel_q + 4'd1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= 4'd0;
            sel_q   <= 4'b0000;
            grant_q <= '0;
            busy_q  <= 1'b0;
            cnt_q   <= 4'd0;
            data_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign sel        = sel_q;
    assign grant      = grant_q;
    assign busy       = busy_q;
    assign data_out   = data_q;
    assign data_valid = valid_q;

endmodule
